// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester arbiter in front of the Data_Memory line port
//
// Purpose: shares the single Data_Memory enable/write/ack port between the
// D-cache controller (port 0) and a second requester (port 1). The winning
// request is latched and forwarded unchanged for the whole transaction, the
// memory ack is routed combinationally back to the owner, and a watchdog
// completes a transaction with an error if the memory never answers.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   reqN_enable_i                request valid, held by requester N until its ack
//   reqN_write_i/addr_i/data_i   request kind, line address, write data
//   reqN_ack_o                   one-cycle completion pulse to requester N
//   reqN_data_o                  read data, meaningful only while reqN_ack_o = 1
//   mem_enable_o/write_o/addr_o/data_o   forwarded request to Data_Memory
//   mem_ack_i, mem_data_i        completion and read data from Data_Memory
//   grant_o                      one-hot owner of the memory, 00 when not BUSY
//   busy_o                       transaction in flight or in its release cycle
//   err_o                        sticky ack-timeout flag, cleared only by rst_i

module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 256,
  parameter int FIXED_PRIO  = 0,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              req0_enable_i,
  input  logic              req0_write_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [DATA_W-1:0] req0_data_i,
  output logic              req0_ack_o,
  output logic [DATA_W-1:0] req0_data_o,

  input  logic              req1_enable_i,
  input  logic              req1_write_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [DATA_W-1:0] req1_data_i,
  output logic              req1_ack_o,
  output logic [DATA_W-1:0] req1_data_o,

  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i,

  output logic [1:0]        grant_o,
  output logic              busy_o,
  output logic              err_o
);

  // Counter only ever needs to hold TIMEOUT_CYC-1; keep at least one bit so a
  // disabled watchdog still elaborates.
  localparam int CNT_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int TO_LAST_I = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_grant_q;   // index of the port granted most recently
  logic [1:0]        grant_q;
  logic              lat_write_q;
  logic [ADDR_W-1:0] lat_addr_q;
  logic [DATA_W-1:0] lat_data_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              err_q;

  logic              capture;
  logic              pick1;
  logic              done;
  logic              timeout;
  logic              ack0, ack1;
  logic [DATA_W-1:0] data0, data1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    pick1   = 1'b0;
    done    = 1'b0;
    timeout = 1'b0;
    ack0    = 1'b0;
    ack1    = 1'b0;
    data0   = '0;
    data1   = '0;

    case (state_q)
      ST_IDLE: begin
        if (req0_enable_i || req1_enable_i) begin
          capture = 1'b1;
          state_d = ST_BUSY;
          if (FIXED_PRIO != 0) begin
            pick1 = ~req0_enable_i;
          end else if (req0_enable_i && req1_enable_i) begin
            pick1 = ~last_grant_q;
          end else begin
            pick1 = req1_enable_i;
          end
        end
      end

      ST_BUSY: begin
        // cnt_q counts completed BUSY cycles, so cnt_q == TIMEOUT_CYC-1 means
        // this is BUSY cycle number TIMEOUT_CYC. A real ack in that same cycle
        // wins and is treated as a normal completion.
        timeout = (TIMEOUT_CYC != 0) && !mem_ack_i && (cnt_q == TO_LAST);
        done    = mem_ack_i || timeout;
        if (done) begin
          state_d = ST_RELEASE;
        end
        ack0 = done && grant_q[0];
        ack1 = done && grant_q[1];
        if (mem_ack_i) begin
          data0 = grant_q[0] ? mem_data_i : '0;
          data1 = grant_q[1] ? mem_data_i : '0;
        end
      end

      ST_RELEASE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant_q <= 1'b1;
      grant_q      <= 2'b00;
      lat_write_q  <= 1'b0;
      lat_addr_q   <= '0;
      lat_data_q   <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else if (capture) begin
      // The winner's inputs are sampled exactly once; later changes on its
      // request lines are ignored until the next grant.
      grant_q      <= pick1 ? 2'b10 : 2'b01;
      last_grant_q <= pick1;
      lat_write_q  <= pick1 ? req1_write_i : req0_write_i;
      lat_addr_q   <= pick1 ? req1_addr_i  : req0_addr_i;
      lat_data_q   <= pick1 ? req1_data_i  : req0_data_i;
      cnt_q        <= '0;
    end else if (state_q == ST_BUSY) begin
      if (done) begin
        grant_q <= 2'b00;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (timeout) begin
        err_q <= 1'b1;
      end
    end
  end

  // Forwarded request is gated to BUSY so Data_Memory sees all-zero inputs
  // in IDLE and RELEASE.
  assign mem_enable_o = (state_q == ST_BUSY);
  assign mem_write_o  = mem_enable_o && lat_write_q;
  assign mem_addr_o   = mem_enable_o ? lat_addr_q : '0;
  assign mem_data_o   = mem_enable_o ? lat_data_q : '0;

  assign req0_ack_o  = ack0;
  assign req1_ack_o  = ack1;
  assign req0_data_o = data0;
  assign req1_data_o = data1;

  assign grant_o = grant_q;
  assign busy_o  = (state_q != ST_IDLE);
  assign err_o   = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam logic [255:0] PAT_LINE =
    256'h0000111122223333444455556666777788889999AAAABBBBCCCCDDDDEEEEFFFF;
  localparam logic [255:0] PAT_A5 = {32{8'hA5}};
  localparam logic [255:0] LINE1  = {8{32'hC0DE0001}};

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic         r0_en, r0_wr, r1_en, r1_wr;
  logic [31:0]  r0_addr, r1_addr;
  logic [255:0] r0_data, r1_data;
  logic         r0_ack, r1_ack;
  logic [255:0] r0_dout, r1_dout;
  logic         m_en, m_wr, m_ack;
  logic [31:0]  m_addr;
  logic [255:0] m_dout, m_din;
  logic [1:0]   grant;
  logic         busy, err;

  logic         f0_en, f1_en;
  logic         f0_ack, f1_ack;
  logic [255:0] f0_dout, f1_dout;
  logic         fm_en, fm_wr;
  logic [31:0]  fm_addr;
  logic [255:0] fm_dout;
  logic [1:0]   fgrant;
  logic         fbusy, ferr;

  mem_arbiter #(.ADDR_W(32), .DATA_W(256), .FIXED_PRIO(0), .TIMEOUT_CYC(64)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .req0_enable_i(r0_en), .req0_write_i(r0_wr), .req0_addr_i(r0_addr), .req0_data_i(r0_data),
    .req0_ack_o(r0_ack), .req0_data_o(r0_dout),
    .req1_enable_i(r1_en), .req1_write_i(r1_wr), .req1_addr_i(r1_addr), .req1_data_i(r1_data),
    .req1_ack_o(r1_ack), .req1_data_o(r1_dout),
    .mem_enable_o(m_en), .mem_write_o(m_wr), .mem_addr_o(m_addr), .mem_data_o(m_dout),
    .mem_ack_i(m_ack), .mem_data_i(m_din),
    .grant_o(grant), .busy_o(busy), .err_o(err)
  );

  // Fixed-priority instance; its memory acks in the first BUSY cycle.
  mem_arbiter #(.ADDR_W(32), .DATA_W(256), .FIXED_PRIO(1), .TIMEOUT_CYC(64)) u_fix (
    .clk_i(clk), .rst_i(rst),
    .req0_enable_i(f0_en), .req0_write_i(1'b0), .req0_addr_i(32'h0), .req0_data_i(256'h0),
    .req0_ack_o(f0_ack), .req0_data_o(f0_dout),
    .req1_enable_i(f1_en), .req1_write_i(1'b0), .req1_addr_i(32'h0), .req1_data_i(256'h0),
    .req1_ack_o(f1_ack), .req1_data_o(f1_dout),
    .mem_enable_o(fm_en), .mem_write_o(fm_wr), .mem_addr_o(fm_addr), .mem_data_o(fm_dout),
    .mem_ack_i(fm_en), .mem_data_i(256'h0),
    .grant_o(fgrant), .busy_o(fbusy), .err_o(ferr)
  );

  // Data_Memory model: acks in the lat-th enabled cycle, 32-byte lines.
  logic [255:0] mem [0:63];
  int lat = 10;
  bit never_ack = 1'b0;
  int mcnt = 0;
  assign m_ack = m_en && !never_ack && (mcnt == lat - 1);
  assign m_din = mem[m_addr[10:5]];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++)
        mem[i] <= (i == 0) ? PAT_LINE : {8{32'hC0DE0000 | 32'(i)}};
      mcnt <= 0;
    end else begin
      if (m_en && m_ack && m_wr) mem[m_addr[10:5]] <= m_dout;
      mcnt <= (m_en && !m_ack) ? mcnt + 1 : 0;
    end
  end

  int n_ack0 = 0, n_ack1 = 0, n_en = 0, nf0 = 0, nf1 = 0;
  always @(negedge clk) begin
    if (r0_ack) n_ack0 <= n_ack0 + 1;
    if (r1_ack) n_ack1 <= n_ack1 + 1;
    if (m_en)   n_en   <= n_en + 1;
    if (f0_ack) nf0    <= nf0 + 1;
    if (f1_ack) nf1    <= nf1 + 1;
  end

  int n_chk = 0, n_err = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ack(input int port, input int maxc, input string tag);
    int n = 0;
    while (!((port == 0) ? r0_ack : r1_ack) && n < maxc) begin
      tick();
      n++;
    end
    check_eq(tag, 256'((port == 0) ? r0_ack : r1_ack), 256'd1);
  endtask

  task automatic serve_tie(input string tag);
    int ord = 0;
    int n = 0;
    r0_wr = 1'b0; r1_wr = 1'b0; r0_addr = 32'h0; r1_addr = 32'h20;
    r0_en = 1'b1; r1_en = 1'b1;
    while ((r0_en || r1_en) && n < 200) begin
      tick();
      n++;
      if (r0_ack) begin ord = ord * 10 + 1; r0_en = 1'b0; end
      if (r1_ack) begin ord = ord * 10 + 2; r1_en = 1'b0; end
    end
    check_eq(tag, 256'(ord), 256'd12);
    repeat (3) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a0, a1, e0, g, cyc, fb;
    rst = 1'b1;
    r0_en = 1'b0; r0_wr = 1'b0; r0_addr = '0; r0_data = '0;
    r1_en = 1'b0; r1_wr = 1'b0; r1_addr = '0; r1_data = '0;
    f0_en = 1'b0; f1_en = 1'b0;
    repeat (3) tick();
    check_eq("rst_mem_en", 256'(m_en), 256'd0);
    check_eq("rst_grant", 256'(grant), 256'd0);
    check_eq("rst_busy", 256'(busy), 256'd0);
    check_eq("rst_err", 256'(err), 256'd0);
    check_eq("rst_acks", 256'({r0_ack, r1_ack}), 256'd0);
    rst = 1'b0;
    tick();

    // 1: read of line 0 with a 10-cycle memory
    lat = 10;
    a0 = n_ack0; a1 = n_ack1; e0 = n_en;
    r0_wr = 1'b0; r0_addr = 32'h0; r0_en = 1'b1;
    tick();
    check_eq("t1_grant", 256'(grant), 256'd1);
    check_eq("t1_mem_en", 256'(m_en), 256'd1);
    check_eq("t1_mem_wr", 256'(m_wr), 256'd0);
    wait_ack(0, 100, "t1_ack");
    check_eq("t1_data", r0_dout, PAT_LINE);
    check_eq("t1_ack1_quiet", 256'(r1_ack), 256'd0);
    r0_en = 1'b0;
    tick();
    check_eq("t1_rel_en", 256'(m_en), 256'd0);
    check_eq("t1_rel_grant", 256'(grant), 256'd0);
    check_eq("t1_rel_busy", 256'(busy), 256'd1);
    tick();
    check_eq("t1_idle_busy", 256'(busy), 256'd0);
    check_eq("t1_en_cycles", 256'(n_en - e0), 256'd10);
    check_eq("t1_ack_count", 256'(n_ack0 - a0), 256'd1);

    // 6: back-to-back requests from port 0
    lat = 3;
    r0_addr = 32'h0; r0_en = 1'b1;
    wait_ack(0, 50, "t6_ack_a");
    check_eq("t6_data_a", r0_dout, PAT_LINE);
    r0_en = 1'b0;
    tick();
    r0_en = 1'b1; r0_addr = 32'h20;
    g = 0;
    while (!m_en && g < 10) begin
      g++;
      tick();
    end
    check_eq("t6_gap", 256'(g), 256'd2);
    check_eq("t6_addr_b", 256'(m_addr), 256'h20);
    wait_ack(0, 50, "t6_ack_b");
    check_eq("t6_data_b", r0_dout, LINE1);
    r0_en = 1'b0;
    repeat (2) tick();

    // 3: port 1 write of line 16
    a0 = n_ack0;
    r1_wr = 1'b1; r1_addr = 32'h200; r1_data = PAT_A5; r1_en = 1'b1;
    tick();
    check_eq("t3_grant", 256'(grant), 256'd2);
    check_eq("t3_mem_wr", 256'(m_wr), 256'd1);
    check_eq("t3_mem_addr", 256'(m_addr), 256'h200);
    check_eq("t3_mem_data", m_dout, PAT_A5);
    wait_ack(1, 50, "t3_ack");
    r1_en = 1'b0; r1_wr = 1'b0;
    tick();
    check_eq("t3_mem16", mem[16], PAT_A5);
    check_eq("t3_no_ack0", 256'(n_ack0 - a0), 256'd0);
    tick();

    // 2: simultaneous requests after reset, round-robin
    do_reset();
    serve_tie("t2_order_a");
    serve_tie("t2_order_b");

    // 2: fixed priority starves port 1 while port 0 is held
    fb = nf1; a0 = nf0;
    f0_en = 1'b1; f1_en = 1'b1;
    repeat (20) tick();
    check_eq("fix_p1_starved", 256'(nf1 - fb), 256'd0);
    check_eq("fix_p0_count", 256'(nf0 - a0), 256'd7);
    f0_en = 1'b0;
    g = 0;
    while (!f1_ack && g < 20) begin
      g++;
      tick();
    end
    check_eq("fix_p1_ack", 256'(f1_ack), 256'd1);
    check_eq("fix_p1_grant", 256'(fgrant), 256'd2);
    f1_en = 1'b0;
    repeat (3) tick();

    // 4: watchdog with a silent memory
    check_eq("t4_err_before", 256'(err), 256'd0);
    never_ack = 1'b1;
    r0_wr = 1'b0; r0_addr = 32'h0; r0_en = 1'b1;
    tick();
    cyc = 1;
    while (!r0_ack && cyc < 200) begin
      tick();
      cyc++;
    end
    check_eq("t4_cycle", 256'(cyc), 256'd64);
    check_eq("t4_data0", r0_dout, 256'h0);
    r0_en = 1'b0;
    tick();
    check_eq("t4_err", 256'(err), 256'd1);
    check_eq("t4_rel_en", 256'(m_en), 256'd0);
    never_ack = 1'b0;
    lat = 3;
    tick();
    r1_wr = 1'b0; r1_addr = 32'h20; r1_en = 1'b1;
    wait_ack(1, 50, "t4_good_ack");
    check_eq("t4_good_data", r1_dout, LINE1);
    r1_en = 1'b0;
    tick();
    check_eq("t4_err_sticky", 256'(err), 256'd1);
    tick();

    // 5: reset in BUSY cycle 5 of a port 1 read
    lat = 20;
    r1_wr = 1'b0; r1_addr = 32'h40; r1_en = 1'b1;
    tick();
    repeat (4) tick();
    check_eq("t5_busy_pre", 256'(m_en), 256'd1);
    a1 = n_ack1;
    rst = 1'b1;
    tick();
    check_eq("t5_en", 256'(m_en), 256'd0);
    check_eq("t5_grant", 256'(grant), 256'd0);
    check_eq("t5_busy", 256'(busy), 256'd0);
    check_eq("t5_err", 256'(err), 256'd0);
    check_eq("t5_ack1", 256'(r1_ack), 256'd0);
    r1_en = 1'b0;
    rst = 1'b0;
    tick();
    check_eq("t5_no_ack1", 256'(n_ack1 - a1), 256'd0);
    lat = 3;
    r0_addr = 32'h20; r0_en = 1'b1;
    tick();
    check_eq("t5_new_grant", 256'(grant), 256'd1);
    wait_ack(0, 50, "t5_new_ack");
    check_eq("t5_new_data", r0_dout, LINE1);
    r0_en = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
